q_hs_arbiter: RTL



---
 rtl/q_arb_pkg.sv | 20 ++
 rtl/q_sync.sv | 23 ++
 rtl/q_hs_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/q_arb_pkg.sv
// Shared definitions for the q_hs_arbiter handshake arbiter: state encoding
// and default synchronizer depth / watchdog limit.
package q_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_RTZ  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    ACK  = ST_ACK,
    RTZ  = ST_RTZ
  } state_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/q_sync.sv
// Multi-flop synchronizer for one asynchronous level signal, cleared by a
// synchronous active-low reset.
module q_sync
  import q_arb_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/q_hs_arbiter.sv
// 2:1 round-robin four-phase handshake arbiter in front of one shared stage.
// Optional watchdog on REQ/RTZ dwell time enabled by Q_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; waiting for a request with the stage acknowledge low
// REQ   | r_out high, waiting for the stage acknowledge
// ACK   | ack[sel] high, waiting for the granted request to fall
// RTZ   | r_out low, waiting for the stage acknowledge to fall
module q_hs_arbiter
  import q_arb_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic ack0,
  output logic ack1,
  output logic r_out,
  input  logic a_out,
  output logic sel,
  output logic busy,
  output logic err
);

  logic   req0_s, req1_s, a_out_s;
  state_t state;
  logic   last;
  logic   grant_idx;
  logic   req_sel_s;
  logic   advance;

  q_sync #(.STAGES(SYNC_STAGES)) u_sync_req0 (.clk(clk), .rst(rst), .d(req0),  .q(req0_s));
  q_sync #(.STAGES(SYNC_STAGES)) u_sync_req1 (.clk(clk), .rst(rst), .d(req1),  .q(req1_s));
  q_sync #(.STAGES(SYNC_STAGES)) u_sync_aout (.clk(clk), .rst(rst), .d(a_out), .q(a_out_s));

  // On a tie the requester that was not served last wins.
  assign grant_idx = req1_s & (~req0_s | ~last);
  assign req_sel_s = sel ? req1_s : req0_s;

  always_comb begin
    advance = 1'b0;
    case (state)
      IDLE:    advance = !a_out_s && (req0_s || req1_s);
      REQ:     advance = a_out_s;
      ACK:     advance = !req_sel_s;
      RTZ:     advance = !a_out_s;
      default: advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      sel   <= 1'b0;
      r_out <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      busy  <= 1'b0;
    end else if (advance) begin
      case (state)
        IDLE: begin
          sel   <= grant_idx;
          r_out <= 1'b1;
          busy  <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          ack0  <= ~sel;
          ack1  <= sel;
          state <= ACK;
        end
        ACK: begin
          r_out <= 1'b0;
          state <= RTZ;
        end
        RTZ: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          last  <= sel;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef Q_ARB_TIMEOUT_EN
  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr;
  logic          timing;

  assign timing = (state == REQ) || (state == RTZ);

  // Down-counter reloads on every state change; terminal count latches err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmr <= TMR_LOAD;
      err <= 1'b0;
    end else begin
      if (advance)                   tmr <= TMR_LOAD;
      else if (timing && tmr != '0)  tmr <= tmr - TW'(1);
      if (!advance && timing && tmr == '0) err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

endmodule
